// File: rtl/axis_lookup_dispatcher_if.sv
// ---------------------------------------------------------------------------
// axis_lookup_dispatcher_if
// AXI-Stream bundle used on both sides of the lookup dispatcher.
//   tdata  : stream payload
//   tkeep  : byte enables
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of the packet
//   tdest  : routing destination (only meaningful on the egress side)
// The master modport is the side that drives the beats; the slave modport
// is the side that accepts them.
// ---------------------------------------------------------------------------
interface axis_lookup_dispatcher_if #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int DEST_WIDTH = 3
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DEST_WIDTH-1:0] tdest;

   modport master (output tdata, output tkeep, output tvalid, output tlast,
                   output tdest, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                   input tdest, output tready);
endinterface

// File: rtl/axis_lookup_dispatcher.sv
// ---------------------------------------------------------------------------
// axis_lookup_dispatcher
// Buffers the first HDR_BEATS beats of each ingress packet, sends them as a
// single key to an external classifier, then forwards the packet with the
// returned tdest, drops it, or steers it to DEFAULT_DEST on a miss/timeout.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis (slave)             ingress stream (tdest ignored)
//   m_axis (master)            egress stream with tdest
//   lookup_req_valid/ready/key key handshake, beat0 in the key LSBs
//   lookup_res_valid/hit/dest  classifier result strobe
//   init_done                  classifier table is loaded
//   enable, bypass_dest        enable=0 passes packets through on bypass_dest
//   cnt_clear                  synchronous clear of the statistics
//   pass/drop/timeout_count    saturating statistics
//   state                      current FSM state for debug
// ---------------------------------------------------------------------------
module axis_lookup_dispatcher #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_DEST_WIDTH = 3,
   parameter int HDR_BEATS       = 3,
   parameter int LOOKUP_TIMEOUT  = 255,
   parameter int MISS_MODE       = 0,
   parameter int DEFAULT_DEST    = 0,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   axis_lookup_dispatcher_if.slave                s_axis,
   axis_lookup_dispatcher_if.master               m_axis,
   output logic                                   lookup_req_valid,
   input  logic                                   lookup_req_ready,
   output logic [HDR_BEATS*AXIS_DATA_WIDTH-1:0]   lookup_req_key,
   input  logic                                   lookup_res_valid,
   input  logic                                   lookup_res_hit,
   input  logic [AXIS_DEST_WIDTH-1:0]             lookup_res_dest,
   input  logic                                   init_done,
   input  logic                                   enable,
   input  logic [AXIS_DEST_WIDTH-1:0]             bypass_dest,
   input  logic                                   cnt_clear,
   output logic [CNT_WIDTH-1:0]                   pass_count,
   output logic [CNT_WIDTH-1:0]                   drop_count,
   output logic [CNT_WIDTH-1:0]                   timeout_count,
   output logic [3:0]                             state
);

   localparam int CW = $clog2(HDR_BEATS + 1);
   localparam int TW = $clog2(LOOKUP_TIMEOUT + 1);
   localparam logic [AXIS_DEST_WIDTH-1:0] MISS_DEST = AXIS_DEST_WIDTH'(DEFAULT_DEST);

   localparam logic [3:0] S_INIT        = 4'd0;
   localparam logic [3:0] S_IDLE        = 4'd1;
   localparam logic [3:0] S_HDR         = 4'd2;
   localparam logic [3:0] S_LOOKUP_REQ  = 4'd3;
   localparam logic [3:0] S_LOOKUP_WAIT = 4'd4;
   localparam logic [3:0] S_SEND_HDR    = 4'd5;
   localparam logic [3:0] S_SEND_BODY   = 4'd6;
   localparam logic [3:0] S_DROP        = 4'd7;
   localparam logic [3:0] S_BYPASS      = 4'd8;

   logic [3:0]                 state_q;
   logic [AXIS_DATA_WIDTH-1:0] hdr_data [HDR_BEATS];
   logic [AXIS_KEEP_WIDTH-1:0] hdr_keep [HDR_BEATS];
   logic [HDR_BEATS-1:0]       hdr_last;
   logic [CW-1:0]              beat_cnt;
   logic [CW-1:0]              send_idx;
   logic                       pkt_done;
   logic                       send_armed;
   logic [TW-1:0]              timer;
   logic [AXIS_DEST_WIDTH-1:0] dest_q;

   logic [AXIS_DATA_WIDTH-1:0] hdr_out_data;
   logic [AXIS_KEEP_WIDTH-1:0] hdr_out_keep;
   logic                       hdr_out_last;
   logic                       s_hs;
   logic                       m_hs;
   logic                       timeout_hit;
   logic                       res_hit_evt;
   logic                       miss_evt;
   logic                       last_hdr_beat;
   logic                       pass_inc;
   logic                       drop_inc;
   logic                       timeout_inc;

   assign state            = state_q;
   assign lookup_req_valid = (state_q == S_LOOKUP_REQ);
   assign m_axis.tdest     = dest_q;
   assign s_hs             = s_axis.tvalid && s_axis.tready;
   assign m_hs             = m_axis.tvalid && m_axis.tready;
   assign timeout_hit      = (timer == TW'(LOOKUP_TIMEOUT - 1));
   assign res_hit_evt      = lookup_res_valid && lookup_res_hit;
   // A result in the same cycle as the timeout takes precedence over it.
   assign miss_evt         = (lookup_res_valid && !lookup_res_hit) ||
                             (!lookup_res_valid && timeout_hit);
   assign last_hdr_beat    = (send_idx == beat_cnt - CW'(1));

   // Key slots beyond the beats actually captured read as zero, so a short
   // packet never leaks stale header data from the previous packet.
   always_comb begin
      lookup_req_key = '0;
      for (int i = 0; i < HDR_BEATS; i++) begin
         if (CW'(i) < beat_cnt) begin
            lookup_req_key[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = hdr_data[i];
         end
      end
   end

   // Mux the buffered beat currently being replayed onto the egress port.
   always_comb begin
      hdr_out_data = '0;
      hdr_out_keep = '0;
      hdr_out_last = 1'b0;
      for (int i = 0; i < HDR_BEATS; i++) begin
         if (send_idx == CW'(i)) begin
            hdr_out_data = hdr_data[i];
            hdr_out_keep = hdr_keep[i];
            hdr_out_last = hdr_last[i];
         end
      end
   end

   // Stream steering: header states sink beats, SEND_HDR replays the buffer
   // (held off one cycle by send_armed so the first egress beat trails the
   // lookup result by two cycles), and the body/bypass states wire the
   // ingress straight through so the body has no bubbles.
   always_comb begin
      s_axis.tready = 1'b0;
      m_axis.tvalid = 1'b0;
      m_axis.tdata  = '0;
      m_axis.tkeep  = '0;
      m_axis.tlast  = 1'b0;
      case (state_q)
         S_HDR, S_DROP: s_axis.tready = 1'b1;
         S_SEND_HDR: begin
            m_axis.tvalid = send_armed;
            m_axis.tdata  = hdr_out_data;
            m_axis.tkeep  = hdr_out_keep;
            m_axis.tlast  = hdr_out_last;
         end
         S_SEND_BODY, S_BYPASS: begin
            m_axis.tvalid = s_axis.tvalid;
            s_axis.tready = m_axis.tready;
            m_axis.tdata  = s_axis.tdata;
            m_axis.tkeep  = s_axis.tkeep;
            m_axis.tlast  = s_axis.tlast;
         end
         default: ;
      endcase
   end

   // Statistics events, shared by the counter block below.
   always_comb begin
      pass_inc    = ((state_q == S_SEND_HDR) && m_hs && last_hdr_beat && pkt_done) ||
                    (((state_q == S_SEND_BODY) || (state_q == S_BYPASS)) && s_hs && s_axis.tlast);
      drop_inc    = (state_q == S_LOOKUP_WAIT) && miss_evt && (MISS_MODE == 0);
      timeout_inc = (state_q == S_LOOKUP_WAIT) && !lookup_res_valid && timeout_hit;
   end

   // Main FSM plus header buffer, lookup timer and latched destination.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         beat_cnt   <= '0;
         send_idx   <= '0;
         pkt_done   <= 1'b0;
         send_armed <= 1'b0;
         timer      <= '0;
         dest_q     <= '0;
         hdr_last   <= '0;
         for (int i = 0; i < HDR_BEATS; i++) begin
            hdr_data[i] <= '0;
            hdr_keep[i] <= '0;
         end
      end else begin
         case (state_q)
            S_INIT: if (init_done) state_q <= S_IDLE;
            S_IDLE: begin
               if (s_axis.tvalid) begin
                  if (enable) begin
                     beat_cnt <= '0;
                     pkt_done <= 1'b0;
                     state_q  <= S_HDR;
                  end else begin
                     dest_q  <= bypass_dest;
                     state_q <= S_BYPASS;
                  end
               end
            end
            S_HDR: begin
               if (s_hs) begin
                  for (int i = 0; i < HDR_BEATS; i++) begin
                     if (beat_cnt == CW'(i)) begin
                        hdr_data[i] <= s_axis.tdata;
                        hdr_keep[i] <= s_axis.tkeep;
                        hdr_last[i] <= s_axis.tlast;
                     end
                  end
                  beat_cnt <= beat_cnt + CW'(1);
                  if (s_axis.tlast) pkt_done <= 1'b1;
                  if (s_axis.tlast || (beat_cnt == CW'(HDR_BEATS - 1))) state_q <= S_LOOKUP_REQ;
               end
            end
            S_LOOKUP_REQ: begin
               if (lookup_req_ready) begin
                  timer   <= '0;
                  state_q <= S_LOOKUP_WAIT;
               end
            end
            S_LOOKUP_WAIT: begin
               timer <= timer + TW'(1);
               if (res_hit_evt) begin
                  dest_q     <= lookup_res_dest;
                  send_idx   <= '0;
                  send_armed <= 1'b0;
                  state_q    <= S_SEND_HDR;
               end else if (miss_evt) begin
                  if (MISS_MODE != 0) begin
                     dest_q     <= MISS_DEST;
                     send_idx   <= '0;
                     send_armed <= 1'b0;
                     state_q    <= S_SEND_HDR;
                  end else begin
                     state_q <= pkt_done ? S_IDLE : S_DROP;
                  end
               end
            end
            S_SEND_HDR: begin
               send_armed <= 1'b1;
               if (m_hs) begin
                  if (last_hdr_beat) begin
                     state_q <= pkt_done ? S_IDLE : S_SEND_BODY;
                  end else begin
                     send_idx <= send_idx + CW'(1);
                  end
               end
            end
            S_SEND_BODY, S_BYPASS, S_DROP: begin
               if (s_hs && s_axis.tlast) state_q <= S_IDLE;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   // Saturating statistics; a clear wins over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_count    <= '0;
         drop_count    <= '0;
         timeout_count <= '0;
      end else if (cnt_clear) begin
         pass_count    <= '0;
         drop_count    <= '0;
         timeout_count <= '0;
      end else begin
         if (pass_inc && (pass_count != '1))       pass_count    <= pass_count + CNT_WIDTH'(1);
         if (drop_inc && (drop_count != '1))       drop_count    <= drop_count + CNT_WIDTH'(1);
         if (timeout_inc && (timeout_count != '1)) timeout_count <= timeout_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_axis_lookup_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_axis_lookup_dispatcher
// Two dispatchers share one stimulus path: dut0 drops on a miss, dut1
// forwards misses to DEFAULT_DEST=7 and has 2-bit counters so saturation is
// reachable. "sel" routes the stream, lookup handshake and observed outputs
// to one of them; the other sees idle inputs.
// ---------------------------------------------------------------------------
module tb_axis_lookup_dispatcher;

   localparam int DW = 64;
   localparam int KW = 8;
   localparam int DESTW = 3;
   localparam int HB = 3;
   localparam int TO = 4;
   localparam int M_HIT = 0;
   localparam int M_MISS = 1;
   localparam int M_NONE = 2;

   typedef struct {
      logic       sel;
      int         nbeats;
      logic       en;
      logic [2:0] byp;
      int         mode;
      logic [2:0] rdest;
      int         delay;
      logic       toggle;
      int         exp_beats;
      logic [2:0] exp_dest;
      int         exp_pass;
      int         exp_drop;
      int         exp_to;
      logic       exp_body;
      int         exp_wait;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic sel;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic s_tvalid, s_tlast, m_tready;
   logic req_ready, res_valid, res_hit;
   logic [DESTW-1:0] res_dest, bypass_dest;
   logic init_done, enable, cnt_clear;

   int compared = 0;
   int mismatched = 0;
   logic drv_done, rsp_done, seen_body;
   int wait_cycles;
   vec_t vecs[12];

   always #5 clk = ~clk;

   axis_lookup_dispatcher_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)) s0 ();
   axis_lookup_dispatcher_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)) m0 ();
   axis_lookup_dispatcher_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)) s1 ();
   axis_lookup_dispatcher_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DESTW)) m1 ();

   assign s0.tdata = s_tdata;  assign s1.tdata = s_tdata;
   assign s0.tkeep = s_tkeep;  assign s1.tkeep = s_tkeep;
   assign s0.tlast = s_tlast;  assign s1.tlast = s_tlast;
   assign s0.tdest = '0;       assign s1.tdest = '0;
   assign s0.tvalid = s_tvalid && !sel;
   assign s1.tvalid = s_tvalid && sel;
   assign m0.tready = m_tready && !sel;
   assign m1.tready = m_tready && sel;

   logic req_valid0, req_valid1;
   logic [HB*DW-1:0] key0, key1;
   logic [31:0] pass0, drop0, to0;
   logic [1:0] pass1, drop1, to1;
   logic [3:0] state0, state1;

   axis_lookup_dispatcher #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(DESTW),
      .HDR_BEATS(HB), .LOOKUP_TIMEOUT(TO), .MISS_MODE(0), .DEFAULT_DEST(7), .CNT_WIDTH(32)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
      .lookup_req_valid(req_valid0), .lookup_req_ready(req_ready && !sel), .lookup_req_key(key0),
      .lookup_res_valid(res_valid && !sel), .lookup_res_hit(res_hit), .lookup_res_dest(res_dest),
      .init_done(init_done), .enable(enable), .bypass_dest(bypass_dest), .cnt_clear(cnt_clear && !sel),
      .pass_count(pass0), .drop_count(drop0), .timeout_count(to0), .state(state0)
   );

   axis_lookup_dispatcher #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(DESTW),
      .HDR_BEATS(HB), .LOOKUP_TIMEOUT(TO), .MISS_MODE(1), .DEFAULT_DEST(7), .CNT_WIDTH(2)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
      .lookup_req_valid(req_valid1), .lookup_req_ready(req_ready && sel), .lookup_req_key(key1),
      .lookup_res_valid(res_valid && sel), .lookup_res_hit(res_hit), .lookup_res_dest(res_dest),
      .init_done(init_done), .enable(enable), .bypass_dest(bypass_dest), .cnt_clear(cnt_clear && sel),
      .pass_count(pass1), .drop_count(drop1), .timeout_count(to1), .state(state1)
   );

   // Views of whichever DUT is currently selected.
   logic s_tready, m_tvalid, m_tlast, req_valid;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [DESTW-1:0] m_tdest;
   logic [HB*DW-1:0] req_key;
   logic [31:0] pass_c, drop_c, to_c;
   logic [3:0] state_m;
   assign s_tready  = sel ? s1.tready : s0.tready;
   assign m_tvalid  = sel ? m1.tvalid : m0.tvalid;
   assign m_tdata   = sel ? m1.tdata  : m0.tdata;
   assign m_tkeep   = sel ? m1.tkeep  : m0.tkeep;
   assign m_tlast   = sel ? m1.tlast  : m0.tlast;
   assign m_tdest   = sel ? m1.tdest  : m0.tdest;
   assign req_valid = sel ? req_valid1 : req_valid0;
   assign req_key   = sel ? key1 : key0;
   assign pass_c    = sel ? {30'd0, pass1} : pass0;
   assign drop_c    = sel ? {30'd0, drop1} : drop0;
   assign to_c      = sel ? {30'd0, to1}   : to0;
   assign state_m   = sel ? state1 : state0;

   function automatic logic [63:0] pat(input int idx, input int i);
      return {8'hA5, 8'(idx), 16'hC0DE, 16'(i * 17 + 3), 16'(idx * 256 + i)};
   endfunction

   function automatic logic [HB*DW-1:0] expKey(input int idx, input int n);
      logic [HB*DW-1:0] k;
      k = '0;
      for (int i = 0; i < HB; i++) begin
         if (i < n) k[i*DW +: DW] = pat(idx, i);
      end
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic noteTimeout(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic driveBeats(input int idx, input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         s_tdata  = pat(idx, i);
         s_tkeep  = (i == n - 1) ? 8'h0F : 8'hFF;
         s_tlast  = (i == n - 1);
         s_tvalid = 1'b1;
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!s_tready && guard < 300);
         if (!s_tready) begin
            noteTimeout("ingress_stall");
            break;
         end
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      drv_done = 1'b1;
   endtask

   task automatic respond(input vec_t v, input int idx);
      int guard;
      logic seen;
      if (!v.en) begin
         seen = 1'b0;
         while (!drv_done) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
         end
         checkOutput("no_lookup_req", seen, 0);
      end else begin
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (!req_valid && guard < 300);
         if (!req_valid) begin
            noteTimeout("lookup_req_wait");
         end else begin
            checkOutput("lookup_key", req_key, expKey(idx, v.nbeats));
            @(negedge clk);
            checkOutput("key_hold", {req_valid, req_key}, {1'b1, expKey(idx, v.nbeats)});
            req_ready = 1'b1;
            @(posedge clk);
            #1;
            req_ready = 1'b0;
            if (v.mode != M_NONE) begin
               for (int k = 0; k < v.delay; k++) begin
                  @(posedge clk);
                  #1;
               end
               res_valid = 1'b1;
               res_hit   = (v.mode == M_HIT);
               res_dest  = v.rdest;
               @(posedge clk);
               #1;
               res_valid = 1'b0;
               res_hit   = 1'b0;
            end
         end
      end
      rsp_done = 1'b1;
   endtask

   task automatic monitorOut(input vec_t v, input int idx);
      int k, cyc, extra;
      logic prev_stall, finished;
      logic [DW-1:0] prev_data;
      k = 0; cyc = 0; extra = 0;
      prev_stall = 1'b0; finished = 1'b0; prev_data = '0;
      m_tready = 1'b1;
      while (!finished && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (state_m == 4'd6 || state_m == 4'd7) seen_body = 1'b1;
         if (state_m == 4'd4) wait_cycles++;
         if (prev_stall) checkOutput("hold_stable", {m_tvalid, m_tdata}, {1'b1, prev_data});
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         if (m_tvalid && m_tready) begin
            if (k < v.exp_beats) begin
               checkOutput("egress_data", m_tdata, pat(idx, k));
               checkOutput("egress_keep", m_tkeep, (k == v.exp_beats - 1) ? 8'h0F : 8'hFF);
               checkOutput("egress_last", m_tlast, (k == v.exp_beats - 1));
               checkOutput("egress_dest", m_tdest, v.exp_dest);
            end else begin
               checkOutput("extra_beat", k + 1, v.exp_beats);
            end
            k++;
         end
         if (v.exp_beats > 0) begin
            finished = (k == v.exp_beats);
         end else if (drv_done && rsp_done) begin
            extra++;
            finished = (extra > 3);
         end
         if (!finished) begin
            @(posedge clk);
            #1;
            if (v.toggle) m_tready = !m_tready;
         end
      end
      if (!finished) noteTimeout("egress_wait");
      checkOutput("beat_count", k, v.exp_beats);
      m_tready = 1'b1;
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      v = vecs[idx];
      @(posedge clk);
      #1;
      sel = v.sel;
      enable = v.en;
      bypass_dest = v.byp;
      drv_done = 1'b0;
      rsp_done = 1'b0;
      seen_body = 1'b0;
      wait_cycles = 0;
      fork
         driveBeats(idx, v.nbeats);
         respond(v, idx);
         monitorOut(v, idx);
      join
      repeat (3) @(negedge clk);
      checkOutput("pass_count", pass_c, v.exp_pass);
      checkOutput("drop_count", drop_c, v.exp_drop);
      checkOutput("timeout_count", to_c, v.exp_to);
      checkOutput("end_state_idle", state_m, 4'd1);
      checkOutput("body_or_drop_seen", seen_body, v.exp_body);
      checkOutput("wait_cycles", wait_cycles, v.exp_wait);
   endtask

   // Watchdog so a wedged DUT can never hang the run.
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // sel nbeats en byp mode rdest delay toggle | beats dest pass drop to body wait
      vecs[0]  = '{1'b0, 6, 1'b1, 3'd0, M_HIT,  3'd5, 1, 1'b0, 6, 3'd5, 1, 0, 0, 1'b1, 2};
      vecs[1]  = '{1'b0, 2, 1'b1, 3'd0, M_HIT,  3'd2, 0, 1'b0, 2, 3'd2, 2, 0, 0, 1'b0, 1};
      vecs[2]  = '{1'b0, 8, 1'b1, 3'd0, M_MISS, 3'd0, 2, 1'b0, 0, 3'd0, 2, 1, 0, 1'b1, 3};
      vecs[3]  = '{1'b0, 6, 1'b1, 3'd0, M_NONE, 3'd0, 0, 1'b0, 0, 3'd0, 2, 2, 1, 1'b1, 4};
      vecs[4]  = '{1'b0, 5, 1'b1, 3'd0, M_HIT,  3'd6, 3, 1'b0, 5, 3'd6, 3, 2, 1, 1'b1, 4};
      vecs[5]  = '{1'b0, 7, 1'b1, 3'd0, M_HIT,  3'd1, 0, 1'b1, 7, 3'd1, 4, 2, 1, 1'b1, 1};
      vecs[6]  = '{1'b0, 4, 1'b0, 3'd3, M_HIT,  3'd0, 0, 1'b1, 4, 3'd3, 5, 2, 1, 1'b0, 0};
      vecs[7]  = '{1'b0, 2, 1'b1, 3'd0, M_MISS, 3'd0, 1, 1'b0, 0, 3'd0, 5, 3, 1, 1'b0, 2};
      vecs[8]  = '{1'b1, 8, 1'b1, 3'd0, M_MISS, 3'd0, 0, 1'b0, 8, 3'd7, 1, 0, 0, 1'b1, 1};
      vecs[9]  = '{1'b1, 3, 1'b1, 3'd0, M_NONE, 3'd0, 0, 1'b0, 3, 3'd7, 2, 0, 1, 1'b0, 4};
      vecs[10] = '{1'b1, 1, 1'b1, 3'd0, M_HIT,  3'd4, 2, 1'b1, 1, 3'd4, 3, 0, 1, 1'b0, 3};
      vecs[11] = '{1'b1, 2, 1'b1, 3'd0, M_HIT,  3'd5, 0, 1'b0, 2, 3'd5, 3, 0, 1, 1'b0, 1};

      rst_n = 1'b0; sel = 1'b0;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      req_ready = 1'b0; res_valid = 1'b0; res_hit = 1'b0; res_dest = '0;
      init_done = 1'b0; enable = 1'b1; bypass_dest = '0; cnt_clear = 1'b0;
      drv_done = 1'b0; rsp_done = 1'b0; seen_body = 1'b0; wait_cycles = 0;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_state", state_m, 4'd0);
      checkOutput("rst_req_valid", req_valid, 0);
      checkOutput("rst_m_tvalid", m_tvalid, 0);
      checkOutput("rst_m_tdest", m_tdest, 0);
      checkOutput("rst_s_tready", s_tready, 0);
      checkOutput("rst_counters", {pass_c, drop_c, to_c}, 0);

      // Stay in INIT while the classifier table is not loaded.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("init_hold_state", state_m, 4'd0);
         checkOutput("init_hold_tready", s_tready, 0);
      end
      init_done = 1'b1;
      @(negedge clk);
      checkOutput("init_to_idle_dut0", state0, 4'd1);
      checkOutput("init_to_idle_dut1", state1, 4'd1);

      for (int i = 0; i < 12; i++) applyStimulus(i);

      // Clear statistics on dut0.
      @(posedge clk);
      #1;
      sel = 1'b0;
      cnt_clear = 1'b1;
      @(posedge clk);
      #1;
      cnt_clear = 1'b0;
      @(negedge clk);
      checkOutput("clear_pass", pass_c, 0);
      checkOutput("clear_drop", drop_c, 0);
      checkOutput("clear_timeout", to_c, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
